// File: rtl/fp16_result_packer.sv
// fp16_result_packer
//   Output end of the FP16 square-root datapath. A core result is packed into
//   an IEEE-754 binary16 word: sign, signed unbiased exponent and a 1.13
//   fixed-point root significand plus sticky. Alternatively, a pre-formed
//   special value is passed through unchanged.
//
//   Stage 1 normalizes the significand with a leading-zero count and adjusts
//   the exponent. Stage 2 rounds to nearest-even, applies the bias, checks for
//   overflow/underflow and registers the packed word.
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   in_valid      input word valid        in_ready     block accepts input
//   in_bypass     emit in_special as-is   in_special   pre-formed FP16 word
//   in_sign       core result sign        in_exp       signed unbiased exponent
//   in_mant       1.(MANT_W-1) root       in_sticky    OR of bits below in_mant
//   out_valid     out_value valid         out_ready    downstream accepts
//   out_value     packed FP16 result      out_inexact  nonzero bits discarded
module fp16_result_packer #(
  parameter int EXP_W  = 7,
  parameter int MANT_W = 14,
  parameter int BIAS   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bypass,
  input  logic [15:0]       in_special,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_sticky,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_value,
  output logic              out_inexact
);

  localparam int LZC_W = $clog2(MANT_W + 1);
  // Exponent after normalization: one extra bit so in_exp - lzc cannot wrap.
  localparam int E1_W  = EXP_W + 1;
  // Exponent after rounding carry and bias: one more bit again.
  localparam int E2_W  = EXP_W + 2;
  // Bits below the 10-bit fraction: guard, round, and the rest feed sticky.
  localparam int GRS_W = MANT_W - 11;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic r_s1_valid;
  logic r_s2_valid;
  logic w_s2_load;
  logic w_s1_advance;

  assign w_s2_load    = !r_s2_valid | out_ready;
  assign w_s1_advance = r_s1_valid & w_s2_load;
  assign in_ready     = !r_s1_valid | w_s1_advance;

  // ---------------------------------------------------------------------------
  // Stage 1: leading-zero count and normalization
  // ---------------------------------------------------------------------------
  logic [LZC_W-1:0]  w_lzc;
  logic              w_mant_zero;
  logic [MANT_W-1:0] w_norm_mant;
  logic [E1_W-1:0]   w_exp1;

  // Scan upward so the most significant set bit determines the count.
  always_comb begin
    w_lzc = LZC_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (in_mant[i]) begin
        w_lzc = LZC_W'(MANT_W - 1 - i);
      end
    end
  end

  assign w_mant_zero = (in_mant == '0);
  assign w_norm_mant = in_mant << w_lzc;
  assign w_exp1      = {in_exp[EXP_W-1], in_exp} - E1_W'(w_lzc);

  logic              r_s1_bypass;
  logic [15:0]       r_s1_special;
  logic              r_s1_sign;
  logic              r_s1_zero;
  logic              r_s1_sticky;
  logic [E1_W-1:0]   r_s1_exp;
  logic [MANT_W-1:0] r_s1_mant;

  // ---------------------------------------------------------------------------
  // Stage 2: round to nearest-even, bias, range check, pack
  // ---------------------------------------------------------------------------
  logic [9:0]              w_frac;
  logic                    w_g;
  logic                    w_r;
  logic                    w_s;
  logic                    w_round_up;
  logic [10:0]             w_frac_sum;
  logic [E2_W-1:0]         w_exp2;
  logic signed [E2_W-1:0]  w_biased;
  logic [15:0]             w_pack_value;
  logic                    w_pack_inexact;

  assign w_frac     = r_s1_mant[MANT_W-2 -: 10];
  assign w_g        = r_s1_mant[GRS_W-1];
  assign w_r        = r_s1_mant[GRS_W-2];
  assign w_s        = (|r_s1_mant[GRS_W-3:0]) | r_s1_sticky;
  assign w_round_up = w_g & (w_r | w_s | w_frac[0]);
  assign w_frac_sum = {1'b0, w_frac} + 11'(w_round_up);
  // A fraction carry-out leaves the fraction bits at zero and bumps the exponent.
  assign w_exp2     = {r_s1_exp[E1_W-1], r_s1_exp} + E2_W'(w_frac_sum[10]);
  assign w_biased   = $signed(w_exp2 + E2_W'(BIAS));

  // Priority: bypass > zero > overflow > underflow > normal.
  always_comb begin
    w_pack_value   = {r_s1_sign, w_biased[4:0], w_frac_sum[9:0]};
    w_pack_inexact = w_g | w_r | w_s;
    if (r_s1_bypass) begin
      w_pack_value   = r_s1_special;
      w_pack_inexact = 1'b0;
    end else if (r_s1_zero) begin
      w_pack_value   = {r_s1_sign, 15'h0000};
      w_pack_inexact = r_s1_sticky;
    end else if (w_biased >= 31) begin
      w_pack_value   = {r_s1_sign, 5'h1F, 10'h000};
      w_pack_inexact = 1'b1;
    end else if (w_biased <= 0) begin
      // Subnormals are not produced: anything below the normal range flushes.
      w_pack_value   = {r_s1_sign, 15'h0000};
      w_pack_inexact = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic [15:0] r_out_value;
  logic        r_out_inexact;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid    <= 1'b0;
      r_s1_bypass   <= 1'b0;
      r_s1_special  <= '0;
      r_s1_sign     <= 1'b0;
      r_s1_zero     <= 1'b0;
      r_s1_sticky   <= 1'b0;
      r_s1_exp      <= '0;
      r_s1_mant     <= '0;
      r_s2_valid    <= 1'b0;
      r_out_value   <= '0;
      r_out_inexact <= 1'b0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_bypass  <= in_bypass;
          r_s1_special <= in_special;
          r_s1_sign    <= in_sign;
          r_s1_zero    <= w_mant_zero;
          r_s1_sticky  <= in_sticky;
          r_s1_exp     <= w_exp1;
          r_s1_mant    <= w_norm_mant;
        end
      end
      // Output data only changes when a new word moves in, so a stalled word
      // stays stable and an emptied stage keeps its last value.
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_value   <= w_pack_value;
          r_out_inexact <= w_pack_inexact;
        end
      end
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_value   = r_out_value;
  assign out_inexact = r_out_inexact;

endmodule
